// File: rtl/thread_regfile_if.sv
// Purpose : Bus bundle between the core sequencer / decoder / ALU / LSU and
//           one per-thread register file.
// Signals :
//   enable                   thread active
//   core_state               core sequencer state (3 bits)
//   block_id                 current block index (8 bits)
//   decoded_rd/rs/rt_address destination / source register addresses
//   decoded_reg_write_enable instruction writes rd
//   decoded_reg_input_mux    00 ALU, 01 LSU, 10 immediate, 11 reserved
//   decoded_immediate        CONST operand
//   alu_out, lsu_out         write-back sources
//   rs, rt                   registered operands returned by the register file
// Modports: master drives the control/data inputs, slave is the register file.
interface thread_regfile_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 enable;
    logic [2:0]           core_state;
    logic [7:0]           block_id;
    logic [3:0]           decoded_rd_address;
    logic [3:0]           decoded_rs_address;
    logic [3:0]           decoded_rt_address;
    logic                 decoded_reg_write_enable;
    logic [1:0]           decoded_reg_input_mux;
    logic [DATA_BITS-1:0] decoded_immediate;
    logic [DATA_BITS-1:0] alu_out;
    logic [DATA_BITS-1:0] lsu_out;
    logic [DATA_BITS-1:0] rs;
    logic [DATA_BITS-1:0] rt;

    modport master (
        output enable, core_state, block_id,
        output decoded_rd_address, decoded_rs_address, decoded_rt_address,
        output decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        output alu_out, lsu_out,
        input  rs, rt
    );

    modport slave (
        input  enable, core_state, block_id,
        input  decoded_rd_address, decoded_rs_address, decoded_rt_address,
        input  decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        input  alu_out, lsu_out,
        output rs, rt
    );
endinterface

// File: rtl/thread_regfile.sv
// Purpose : Per-thread register file, write-back end of the execute datapath.
//           16 registers: R0..R12 writable, R13 mirrors block_id,
//           R14 = THREADS_PER_BLOCK and R15 = THREAD_ID are constants.
//           Operands are latched on REQUEST, results committed on UPDATE.
// Ports   :
//   clk    core clock, rising edge
//   reset  synchronous, active-high; overrides enable and every state
//   bus    thread_regfile_if.slave (control, write-back sources, rs/rt out)
module thread_regfile #(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned THREAD_ID         = 0,
    parameter int unsigned DATA_BITS         = 8
) (
    input  logic              clk,
    input  logic              reset,
    thread_regfile_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } core_state_e;

    localparam logic [DATA_BITS-1:0] C_BLOCK_DIM  = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] C_THREAD_IDX = DATA_BITS'(THREAD_ID);

    logic [DATA_BITS-1:0] r_regs [0:12];
    logic [DATA_BITS-1:0] r_block_idx;
    logic [DATA_BITS-1:0] r_rs;
    logic [DATA_BITS-1:0] r_rt;

    logic [DATA_BITS-1:0] w_view [0:15];
    logic [DATA_BITS-1:0] w_wdata;
    logic                 w_wr;
    core_state_e          w_state;

    assign w_state = core_state_e'(bus.core_state);

    // Architectural view of all 16 registers, read-only ones included.
    always_comb begin
        for (int unsigned i = 0; i < 13; i++) begin
            w_view[i] = r_regs[i];
        end
        w_view[13] = r_block_idx;
        w_view[14] = C_BLOCK_DIM;
        w_view[15] = C_THREAD_IDX;
    end

    always_comb begin
        w_wdata = '0;
        case (bus.decoded_reg_input_mux)
            2'b00:   w_wdata = bus.alu_out;
            2'b01:   w_wdata = bus.lsu_out;
            2'b10:   w_wdata = bus.decoded_immediate;
            default: w_wdata = '0;
        endcase
    end

    // Writes to R13..R15 and the reserved mux code are dropped here.
    assign w_wr = (w_state == S_UPDATE) && bus.decoded_reg_write_enable
                  && (bus.decoded_rd_address <= 4'd12)
                  && (bus.decoded_reg_input_mux != 2'b11);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 13; i++) begin
                r_regs[i] <= '0;
            end
            r_block_idx <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
        end else if (bus.enable) begin
            r_block_idx <= DATA_BITS'(bus.block_id);
            if (w_state == S_REQUEST) begin
                r_rs <= w_view[bus.decoded_rs_address];
                r_rt <= w_view[bus.decoded_rt_address];
            end
            if (w_wr) begin
                r_regs[bus.decoded_rd_address] <= w_wdata;
            end
        end
    end

    assign bus.rs = r_rs;
    assign bus.rt = r_rt;

endmodule
